// File: rtl/triangle_sweep_ctrl.sv
// Segment-table sequencer for a triangle-wave generator: steps low/high bounds at valleys.
// Optional build macro TRI_SWEEP_LOOP_EN makes the sweep wrap to segment 0 instead of finishing.
module triangle_sweep_ctrl #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 2,
   parameter int REP_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [WIDTH-1:0]  cfg_low,
   input  logic [WIDTH-1:0]  cfg_high,
   input  logic [REP_W-1:0]  cfg_reps,
   input  logic              start,
   input  logic              stop,
   input  logic [WIDTH-1:0]  wave_in,
   output logic [WIDTH-1:0]  low_out,
   output logic [WIDTH-1:0]  high_out,
   output logic [ADDR_W-1:0] seg_out,
   output logic              busy,
   output logic              done
);

   localparam int NSEG = 2**ADDR_W;

   typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

   state_t state, state_next;

   logic [WIDTH-1:0] tbl_low  [NSEG];
   logic [WIDTH-1:0] tbl_high [NSEG];
   logic [REP_W-1:0] tbl_reps [NSEG];

   logic [WIDTH-1:0]  prev;
   logic              desc;
   logic [REP_W-1:0]  rep_cnt;
   logic              valley;
   logic              last_seg;
   logic              rep_more;
   logic [REP_W:0]    reps_eff;
   logic [ADDR_W-1:0] seg_next;
   logic              load_first;
   logic              step_seg;
   logic              count_rep;
   logic              finish;

   // The table is storage only; freezing it while busy keeps a running sweep consistent.
   always_ff @(posedge clk) begin
      if (cfg_we && !busy) begin
         tbl_low[cfg_addr]  <= cfg_low;
         tbl_high[cfg_addr] <= cfg_high;
         tbl_reps[cfg_addr] <= cfg_reps;
      end
   end

   assign busy     = (state != IDLE);
   assign valley   = (state == RUN) && desc && (wave_in > prev);
   assign last_seg = (seg_out == ADDR_W'(NSEG-1));
   assign seg_next = seg_out + ADDR_W'(1);
   assign reps_eff = (tbl_reps[seg_out] == '0) ? (REP_W+1)'(1) : {1'b0, tbl_reps[seg_out]};
   assign rep_more = (({1'b0, rep_cnt} + (REP_W+1)'(1)) < reps_eff);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Stop has priority over both start and a coincident valley.
   always_comb begin
      state_next = state;
      load_first = 1'b0;
      step_seg   = 1'b0;
      count_rep  = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start && !stop) begin
               state_next = ARM;
               load_first = 1'b1;
            end
         end
         ARM: begin
            state_next = stop ? IDLE : RUN;
         end
         RUN: begin
            if (stop) begin
               state_next = IDLE;
            end else if (valley) begin
               if (rep_more) begin
                  count_rep = 1'b1;
               end else if (!last_seg) begin
                  step_seg = 1'b1;
               end else begin
                  finish = 1'b1;
`ifdef TRI_SWEEP_LOOP_EN
                  step_seg = 1'b1;
`else
                  state_next = IDLE;
`endif
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // seg_next wraps to 0 after the last entry, which is what the looping build relies on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         low_out  <= '0;
         high_out <= '0;
         seg_out  <= '0;
         rep_cnt  <= '0;
         prev     <= '0;
         desc     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= finish;
         if (load_first) begin
            low_out  <= tbl_low[0];
            high_out <= tbl_high[0];
            seg_out  <= '0;
            rep_cnt  <= '0;
            desc     <= 1'b0;
         end
         if (state == ARM) prev <= wave_in;
         if (state == RUN) begin
            prev <= wave_in;
            if (valley)              desc <= 1'b0;
            else if (wave_in < prev) desc <= 1'b1;
         end
         if (count_rep) rep_cnt <= rep_cnt + REP_W'(1);
         if (step_seg) begin
            seg_out  <= seg_next;
            low_out  <= tbl_low[seg_next];
            high_out <= tbl_high[seg_next];
            rep_cnt  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_triangle_sweep_ctrl.sv
// Directed bench for triangle_sweep_ctrl with a simple step-of-one triangle generator in the loop.
// Generator reversals at the low bound are counted to check periods per segment.
module tb_triangle_sweep_ctrl;

   localparam int WIDTH  = 8;
   localparam int ADDR_W = 2;
   localparam int REP_W  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cfg_we = 1'b0;
   logic [ADDR_W-1:0] cfg_addr = '0;
   logic [WIDTH-1:0]  cfg_low = '0;
   logic [WIDTH-1:0]  cfg_high = '0;
   logic [REP_W-1:0]  cfg_reps = '0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic [WIDTH-1:0]  wave;
   logic [WIDTH-1:0]  low_out;
   logic [WIDTH-1:0]  high_out;
   logic [ADDR_W-1:0] seg_out;
   logic              busy;
   logic              done;

   int check_cnt = 0;
   int pass_cnt  = 0;
   int turns;
   logic gen_up;

   int exp_low  [4] = '{10, 30, 0, 5};
   int exp_high [4] = '{20, 40, 255, 6};
   int exp_reps [4] = '{2, 1, 1, 3};

   triangle_sweep_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .REP_W(REP_W)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_low(cfg_low), .cfg_high(cfg_high), .cfg_reps(cfg_reps),
      .start(start), .stop(stop), .wave_in(wave),
      .low_out(low_out), .high_out(high_out), .seg_out(seg_out),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Triangle generator: ramps by one between the bounds, counting each upward turn at the low bound.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wave   <= '0;
         gen_up <= 1'b1;
         turns  <= 0;
      end else if (low_out >= high_out) begin
         wave <= low_out;
      end else if (gen_up) begin
         if (wave >= high_out) begin
            gen_up <= 1'b0;
            wave   <= wave - 8'd1;
         end else begin
            wave <= wave + 8'd1;
         end
      end else begin
         if (wave <= low_out) begin
            gen_up <= 1'b1;
            wave   <= wave + 8'd1;
            turns  <= turns + 1;
         end else begin
            wave <= wave - 8'd1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      check_cnt++;
      if (obs === expv) pass_cnt++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
   endtask

   task automatic applyStimulus(input int addr, input int lo, input int hi, input int reps);
      cfg_we   = 1'b1;
      cfg_addr = ADDR_W'(addr);
      cfg_low  = WIDTH'(lo);
      cfg_high = WIDTH'(hi);
      cfg_reps = REP_W'(reps);
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   task automatic waitSeg(input int target, input string tag);
      int cyc = 0;
      while (seg_out != ADDR_W'(target) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput(tag, seg_out, target);
   endtask

   task automatic writeTable();
      for (int i = 0; i < 4; i++) applyStimulus(i, exp_low[i], exp_high[i], (i == 2) ? 0 : exp_reps[i]);
   endtask

   initial begin
      int mark;
      int cyc;
      int cur_seg;
      int done_cnt;

      repeat (2) @(negedge clk);
      checkOutput("reset_low", low_out, 0);
      checkOutput("reset_high", high_out, 0);
      checkOutput("reset_seg", seg_out, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      rst = 1'b0;
      writeTable();

`ifndef TRI_SWEEP_LOOP_EN
      // Full sweep: periods per segment 2,1,1,3, then one done pulse with bounds held at 5/6.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("start_busy", busy, 1);
      checkOutput("start_low", low_out, 10);
      checkOutput("start_high", high_out, 20);
      mark = turns;
      cur_seg = 0;
      done_cnt = 0;
      cyc = 0;
      while (busy && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (seg_out != ADDR_W'(cur_seg)) begin
            checkOutput("seg_step", seg_out, cur_seg + 1);
            checkOutput("seg_periods", turns - mark, exp_reps[cur_seg]);
            cur_seg = int'(seg_out);
            mark = turns;
         end
         checkOutput("bounds_low", low_out, exp_low[cur_seg]);
         checkOutput("bounds_high", high_out, exp_high[cur_seg]);
         if (done) begin
            done_cnt++;
            checkOutput("final_periods", turns - mark, 3);
            checkOutput("final_seg", seg_out, 3);
         end
      end
      checkOutput("sweep_timeout", (cyc < 3000) ? 1 : 0, 1);
      checkOutput("done_count", done_cnt, 1);
      checkOutput("end_busy", busy, 0);
      checkOutput("end_low", low_out, 5);
      checkOutput("end_high", high_out, 6);
      @(negedge clk);
      checkOutput("done_one_cycle", done, 0);
`else
      // Looping build: reps=1 everywhere, wrap 3->0 pulses done and busy stays high.
      for (int i = 0; i < 4; i++) applyStimulus(i, exp_low[i], exp_high[i], 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cur_seg = 0;
      done_cnt = 0;
      cyc = 0;
      while (done_cnt < 5 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (seg_out != ADDR_W'(cur_seg)) begin
            checkOutput("loop_seg", seg_out, (cur_seg + 1) % 4);
            checkOutput("loop_done", done, (cur_seg == 3) ? 1 : 0);
            checkOutput("loop_busy", busy, 1);
            cur_seg = int'(seg_out);
            done_cnt++;
         end
      end
      checkOutput("loop_timeout", (cyc < 3000) ? 1 : 0, 1);
      checkOutput("loop_final_seg", seg_out, 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checkOutput("loop_stop_busy", busy, 0);
      writeTable();
`endif

      // A write while busy must not alter entry 1.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      applyStimulus(1, 99, 100, 5);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checkOutput("stop_busy", busy, 0);
      checkOutput("stop_done", done, 0);

      // Rerun with start held high: shows old entry 1, and no restart.
      start = 1'b1;
      @(negedge clk);
      waitSeg(1, "rerun_seg1");
      checkOutput("rerun_low", low_out, 30);
      checkOutput("rerun_high", high_out, 40);
      repeat (5) @(negedge clk);
      checkOutput("held_start_seg", seg_out, 1);
      checkOutput("held_start_busy", busy, 1);
      start = 1'b0;

      // Stop coincident with the final valley of the last segment.
      waitSeg(3, "rerun_seg3");
      mark = turns;
      cyc = 0;
      while (turns - mark < 3 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("final_turn_timeout", (cyc < 100) ? 1 : 0, 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checkOutput("stopvalley_done", done, 0);
      checkOutput("stopvalley_busy", busy, 0);
      checkOutput("stopvalley_low", low_out, 5);
      checkOutput("stopvalley_high", high_out, 6);
      @(negedge clk);
      checkOutput("stopvalley_done_after", done, 0);

      // start and stop together in IDLE.
      start = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      checkOutput("startstop_busy", busy, 0);
      @(negedge clk);
      checkOutput("startstop_busy2", busy, 0);
      start = 1'b0;
      stop = 1'b0;

      // Asynchronous reset while running in segment 2.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitSeg(2, "pre_reset_seg");
      checkOutput("pre_reset_busy", busy, 1);
      rst = 1'b1;
      #1;
      checkOutput("async_low", low_out, 0);
      checkOutput("async_high", high_out, 0);
      checkOutput("async_seg", seg_out, 0);
      checkOutput("async_busy", busy, 0);
      checkOutput("async_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_busy", busy, 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
